cnn_layer_accel_awe_stride_picker_2d: RTL and testbench
=======================================================

Name: cnn_layer_accel_awe_stride_picker_2d

Overview:
Parametrised 2-D successor to the AWE stride picker. It decimates a raster-ordered, multi-channel pixel stream by independent horizontal and vertical strides, keeping pixel (r,c) when r%stride_y==0 and c%stride_x==0. It sits between the AWE output and the downstream accumulator/FIFO. It adds valid/ready backpressure, frame geometry, and end-of-row/end-of-frame markers.

Parameters:
C_DATA_WIDTH, 16, width of one channel sample
C_NUM_CHANNELS, 4, samples carried in parallel per beat
C_MAX_STRIDE, 8, largest legal stride on either axis
C_MAX_ROW_WIDTH, 1024, largest pixels-per-row
C_MAX_NUM_ROWS, 1024, largest rows-per-frame

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
config_valid  in  1  one-cycle pulse; latches config_* fields
config_stride_x  in  SW=clog2(C_MAX_STRIDE+1)  horizontal stride, 1..C_MAX_STRIDE
config_stride_y  in  SW  vertical stride
config_row_width  in  clog2(C_MAX_ROW_WIDTH+1)  pixels per row, >=1
config_num_rows  in  clog2(C_MAX_NUM_ROWS+1)  rows per frame, >=1
datain  in  C_NUM_CHANNELS*C_DATA_WIDTH  input pixel, channel 0 in LSBs
datain_valid  in  1  input beat valid
datain_ready  out  1  input beat accepted when valid&&ready
dataout  out  C_NUM_CHANNELS*C_DATA_WIDTH  kept pixel; all zero when dataout_valid=0
dataout_valid  out  1  output beat valid
dataout_ready  in  1  downstream accept
dataout_eol  out  1  beat is last kept pixel of its row
dataout_eof  out  1  beat is last kept pixel of the frame
frame_done  out  1  one-cycle pulse when last input pixel of a frame is accepted

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; all counters 0; dataout_valid, dataout_eol, dataout_eof, frame_done=0; datain_ready=0; latched config cleared to 0.
- States: IDLE (unconfigured, datain_ready=0) and RUN. config_valid moves IDLE->RUN. In RUN, config_valid restarts the frame: counters cleared, new config latched, and any held output beat kept until it is accepted. RUN never returns to IDLE except by reset.
- Stride 0 on either axis is latched as 1.
- Counters: col_cnt, row_cnt, x_phase (0..stride_x-1), y_phase (0..stride_y-1). All advance only on an accepted input beat (datain_valid&&datain_ready).
- Phase updates:
  - x_phase wraps at stride_x-1 and resets to 0 at end of row.
  - y_phase advances at end of row, wraps at stride_y-1, and resets to 0 at end of frame.
- Keep = (x_phase==0)&&(y_phase==0). A dropped beat is still consumed.
- Output register: one stage. datain_ready = RUN && (!dataout_valid || dataout_ready). A kept beat loads dataout on the accepting edge, so latency is 1 cycle. dataout_valid holds until dataout_ready is high. dataout must not change while valid&&!ready.
- dataout_eol: set on a kept beat when col_cnt + stride_x >= row_width.
- dataout_eof: set with eol when the current row is the last kept row, i.e. row_cnt + stride_y >= num_rows.
- frame_done: pulses on the edge accepting col=row_width-1, row=num_rows-1. Counters then wrap to 0 and the next frame starts with the same config. Back-to-back frames run with no bubble.
- Simultaneous config_valid and an accepted beat: config wins and the beat is dropped (datain_ready is forced 0 that cycle).
- rst_n low mid-frame: all state is abandoned; the held output is discarded.

Decomposition:
- Package cnn_layer_accel_awe_pkg holds the state enum typedef (IDLE, RUN) and clog2-derived width constants for stride, column and row fields.
- One natural sub-module: cnn_layer_accel_awe_axis_counter. It is a wrap counter with inc/clear/limit inputs and a last flag, and is instanced for col/row and x/y phase.

Test Plan:
- Config 4x4 frame, stride 2,2, input values 0..15, dataout_ready=1 -> outputs 0,2,8,10. eol on 2 and 10, eof on 10 only. frame_done pulses with input 15.
- Stride 1,1, 3x2 frame -> all 6 beats pass through in order with 1-cycle latency. eol on the 3rd and 6th beats, eof on the 6th.
- Row width 5, stride_x 3, stride_y 1, 2 rows, input 0..9 -> outputs 0,3,5,8. eol on 3 and 8 (x_phase restarts each row).
- Stride 2,2 on 4x4 with dataout_ready toggling 1,0,0,1 -> datain_ready drops while output is held. Output values are unchanged and no beats are lost or duplicated.
- Stride 0,0 configured -> behaves identically to stride 1,1.
- rst_n low for 1 cycle after 5 input beats -> dataout_valid=0 next cycle and datain_ready=0 until config_valid. After re-config, first output = first new input.

Source files
------------

// File: rtl/cnn_layer_accel_awe_pkg.sv
// Shared types and width helpers for the 2-D AWE stride picker.
// Contents: FSM state enum, default parameter values, clog2-derived widths.
package cnn_layer_accel_awe_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bits needed to hold the value max_val itself (not just max_val-1).
  function automatic int unsigned width_for(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int unsigned DEF_DATA_WIDTH    = 16;
  localparam int unsigned DEF_NUM_CHANNELS  = 4;
  localparam int unsigned DEF_MAX_STRIDE    = 8;
  localparam int unsigned DEF_MAX_ROW_WIDTH = 1024;
  localparam int unsigned DEF_MAX_NUM_ROWS  = 1024;

  localparam int unsigned DEF_STRIDE_W = $clog2(DEF_MAX_STRIDE + 1);
  localparam int unsigned DEF_COL_W    = $clog2(DEF_MAX_ROW_WIDTH + 1);
  localparam int unsigned DEF_ROW_W    = $clog2(DEF_MAX_NUM_ROWS + 1);

endpackage

// File: rtl/cnn_layer_accel_awe_axis_counter.sv
// Wrap counter used for column, row and x/y phase tracking.
// Ports: clk, rst_n (sync, active-low), clear (highest priority), inc,
//        limit (terminal value), count (registered), last_c (count==limit).
module cnn_layer_accel_awe_axis_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         last_c
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign last_c = (count_q == limit);
  assign count  = count_q;

  // Clear wins over increment; increment wraps to 0 after the terminal value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = last_c ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cnn_layer_accel_awe_stride_picker_2d.sv
// 2-D stride decimator for a raster-ordered multi-channel pixel stream.
// Keeps pixel (r,c) when r%stride_y==0 and c%stride_x==0, with valid/ready
// on both sides, a one-deep output register and eol/eof markers.
// Ports: clk, rst_n (sync, active-low); config_* (latched on config_valid);
//        datain/datain_valid/datain_ready (input stream);
//        dataout/dataout_valid/dataout_ready/dataout_eol/dataout_eof (output);
//        frame_done (pulse after the last pixel of a frame is accepted).
module cnn_layer_accel_awe_stride_picker_2d
  import cnn_layer_accel_awe_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned C_NUM_CHANNELS  = DEF_NUM_CHANNELS,
  parameter int unsigned C_MAX_STRIDE    = DEF_MAX_STRIDE,
  parameter int unsigned C_MAX_ROW_WIDTH = DEF_MAX_ROW_WIDTH,
  parameter int unsigned C_MAX_NUM_ROWS  = DEF_MAX_NUM_ROWS,
  localparam int unsigned SW = width_for(C_MAX_STRIDE),
  localparam int unsigned CW = width_for(C_MAX_ROW_WIDTH),
  localparam int unsigned RW = width_for(C_MAX_NUM_ROWS),
  localparam int unsigned DW = C_NUM_CHANNELS * C_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          config_valid,
  input  logic [SW-1:0] config_stride_x,
  input  logic [SW-1:0] config_stride_y,
  input  logic [CW-1:0] config_row_width,
  input  logic [RW-1:0] config_num_rows,
  input  logic [DW-1:0] datain,
  input  logic          datain_valid,
  output logic          datain_ready,
  output logic [DW-1:0] dataout,
  output logic          dataout_valid,
  input  logic          dataout_ready,
  output logic          dataout_eol,
  output logic          dataout_eof,
  output logic          frame_done
);

  localparam int unsigned CWE = CW + 1;
  localparam int unsigned RWE = RW + 1;

  state_e state_q;
  state_e state_d;
  logic   run_c;

  logic [SW-1:0] stride_x_q, stride_x_d;
  logic [SW-1:0] stride_y_q, stride_y_d;
  logic [CW-1:0] row_width_q, row_width_d;
  logic [RW-1:0] num_rows_q, num_rows_d;

  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          dout_eol_q, dout_eol_d;
  logic          dout_eof_q, dout_eof_d;
  logic          frame_done_q, frame_done_d;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [SW-1:0] x_phase;
  logic [SW-1:0] y_phase;
  logic          col_last_c, row_last_c, x_last_c, y_last_c;

  logic          accept_c;
  logic          keep_c;
  logic          eol_c;
  logic          eof_c;
  logic          end_row_c;
  logic          end_frame_c;
  logic [CWE-1:0] col_reach_c;
  logic [RWE-1:0] row_reach_c;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the first config leaves IDLE; only reset returns there.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && config_valid) begin
      state_d = RUN;
    end
  end

  // State-decoded outputs.
  always_comb begin
    run_c = (state_q == RUN);
  end

  // A config pulse blocks the input for one cycle so a coincident beat is dropped.
  assign datain_ready = run_c && !config_valid && (!dout_valid_q || dataout_ready);
  assign accept_c     = datain_valid && datain_ready;
  assign end_row_c    = accept_c && col_last_c;
  assign end_frame_c  = end_row_c && row_last_c;

  assign keep_c      = (x_phase == '0) && (y_phase == '0);
  assign col_reach_c = CWE'(col_cnt) + CWE'(stride_x_q);
  assign row_reach_c = RWE'(row_cnt) + RWE'(stride_y_q);
  assign eol_c       = (col_reach_c >= CWE'(row_width_q));
  assign eof_c       = eol_c && (row_reach_c >= RWE'(num_rows_q));

  cnn_layer_accel_awe_axis_counter #(.W(CW)) u_col_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (config_valid),
    .inc    (accept_c),
    .limit  (row_width_q - CW'(1)),
    .count  (col_cnt),
    .last_c (col_last_c)
  );

  cnn_layer_accel_awe_axis_counter #(.W(RW)) u_row_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (config_valid),
    .inc    (end_row_c),
    .limit  (num_rows_q - RW'(1)),
    .count  (row_cnt),
    .last_c (row_last_c)
  );

  // x phase restarts every row so a row width not divisible by the stride
  // still keeps column 0 of the next row.
  cnn_layer_accel_awe_axis_counter #(.W(SW)) u_x_phase (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (config_valid || end_row_c),
    .inc    (accept_c),
    .limit  (stride_x_q - SW'(1)),
    .count  (x_phase),
    .last_c (x_last_c)
  );

  cnn_layer_accel_awe_axis_counter #(.W(SW)) u_y_phase (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (config_valid || end_frame_c),
    .inc    (end_row_c),
    .limit  (stride_y_q - SW'(1)),
    .count  (y_phase),
    .last_c (y_last_c)
  );

  // Config latch and output register next-state.
  always_comb begin
    stride_x_d   = stride_x_q;
    stride_y_d   = stride_y_q;
    row_width_d  = row_width_q;
    num_rows_d   = num_rows_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_eol_d   = dout_eol_q;
    dout_eof_d   = dout_eof_q;
    frame_done_d = end_frame_c;

    if (config_valid) begin
      stride_x_d  = (config_stride_x == '0) ? SW'(1) : config_stride_x;
      stride_y_d  = (config_stride_y == '0) ? SW'(1) : config_stride_y;
      row_width_d = config_row_width;
      num_rows_d  = config_num_rows;
    end

    // Load on a kept beat; otherwise drain (and zero) once downstream accepts.
    if (accept_c && keep_c) begin
      dout_d       = datain;
      dout_valid_d = 1'b1;
      dout_eol_d   = eol_c;
      dout_eof_d   = eof_c;
    end else if (dataout_ready) begin
      dout_d       = '0;
      dout_valid_d = 1'b0;
      dout_eol_d   = 1'b0;
      dout_eof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stride_x_q   <= '0;
      stride_y_q   <= '0;
      row_width_q  <= '0;
      num_rows_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_eol_q   <= 1'b0;
      dout_eof_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      stride_x_q   <= stride_x_d;
      stride_y_q   <= stride_y_d;
      row_width_q  <= row_width_d;
      num_rows_q   <= num_rows_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_eol_q   <= dout_eol_d;
      dout_eof_q   <= dout_eof_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dataout       = dout_q;
  assign dataout_valid = dout_valid_q;
  assign dataout_eol   = dout_eol_q;
  assign dataout_eof   = dout_eof_q;
  assign frame_done    = frame_done_q;

  // Phase terminal flags are consumed inside the counters themselves.
  logic unused_c;
  assign unused_c = x_last_c ^ y_last_c;

endmodule

// File: tb/tb_cnn_layer_accel_awe_stride_picker_2d.sv
module tb_cnn_layer_accel_awe_stride_picker_2d;

  localparam int SW = 4;
  localparam int CW = 11;
  localparam int RW = 11;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          config_valid;
  logic [SW-1:0] config_stride_x;
  logic [SW-1:0] config_stride_y;
  logic [CW-1:0] config_row_width;
  logic [RW-1:0] config_num_rows;
  logic [DW-1:0] datain;
  logic          datain_valid;
  logic          datain_ready;
  logic [DW-1:0] dataout;
  logic          dataout_valid;
  logic          dataout_ready;
  logic          dataout_eol;
  logic          dataout_eof;
  logic          frame_done;

  cnn_layer_accel_awe_stride_picker_2d dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .config_valid     (config_valid),
    .config_stride_x  (config_stride_x),
    .config_stride_y  (config_stride_y),
    .config_row_width (config_row_width),
    .config_num_rows  (config_num_rows),
    .datain           (datain),
    .datain_valid     (datain_valid),
    .datain_ready     (datain_ready),
    .dataout          (dataout),
    .dataout_valid    (dataout_valid),
    .dataout_ready    (dataout_ready),
    .dataout_eol      (dataout_eol),
    .dataout_eof      (dataout_eof),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          eol;
    logic          eof;
  } exp_t;

  typedef struct {
    int sx;
    int sy;
    int w;
    int h;
    int mode;
    int frames;
    int exp_outs;
  } vec_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   out_cnt = 0;
  int   fd_seen = 0;
  time  last_acc_t = 0;
  int   rdy_mode = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [DW-1:0] pix(input int v);
    logic [DW-1:0] p;
    for (int k = 0; k < 4; k++) p[k*16 +: 16] = 16'(v + k * 4096);
    return p;
  endfunction

  // Downstream ready pattern: 0 always, 1 repeating 1,0,0,1, 2 random, 3 stalled.
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0: dataout_ready = 1'b1;
      1: dataout_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2: dataout_ready = 1'($urandom_range(0, 1));
      default: dataout_ready = 1'b0;
    endcase
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !mon_en) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 64'(dataout_valid), 64'd1);
        chk("hold_data", dataout, prev_data);
      end
      if (dataout_valid && !dataout_ready) chk("ready_low_on_stall", 64'(datain_ready), 64'd0);
      if (!dataout_valid) chk("idle_data_zero", dataout, '0);
      if (dataout_valid && dataout_ready) begin
        out_cnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_out", dataout, '1);
        end else begin
          e = sbq.pop_front();
          chk("out_data", dataout, e.d);
          chk("out_eol", 64'(dataout_eol), 64'(e.eol));
          chk("out_eof", 64'(dataout_eof), 64'(e.eof));
        end
      end
      if (frame_done) begin
        fd_seen++;
        chk("frame_done_time", 64'($time), 64'(last_acc_t + 10));
      end
      prev_hold = dataout_valid && !dataout_ready;
      prev_data = dataout;
    end
  end

  // Config pulse; optionally asserts a coincident beat that must be refused.
  task automatic configure(input int sx, input int sy, input int w, input int h, input bit ovr);
    @(posedge clk); #1;
    config_valid     = 1'b1;
    config_stride_x  = SW'(sx);
    config_stride_y  = SW'(sy);
    config_row_width = CW'(w);
    config_num_rows  = RW'(h);
    if (ovr) begin
      datain_valid = 1'b1;
      datain       = pix(999);
      @(negedge clk);
      chk("config_overrides_beat", 64'(datain_ready), 64'd0);
    end
    @(posedge clk); #1;
    config_valid = 1'b0;
    datain_valid = 1'b0;
  endtask

  task automatic run_beats(input int esx, input int esy, input int w, input int h,
                           input int n, input int base);
    int p, r, c, guard;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      p = i % (w * h);
      r = p / w;
      c = p % w;
      @(posedge clk); #1;
      datain_valid = 1'b1;
      datain       = pix(base + i);
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!datain_ready && guard < 200);
      if (!datain_ready) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
      if ((r % esy) == 0 && (c % esx) == 0) begin
        e.d   = pix(base + i);
        e.eol = (c + esx >= w);
        e.eof = e.eol && (r + esy >= h);
        sbq.push_back(e);
      end
      if (p == w * h - 1) last_acc_t = $time;
    end
    @(posedge clk); #1;
    datain_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (sbq.size() == 0 && !dataout_valid) break;
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int fd0, esx, esy;
    vecs[0] = '{sx:2, sy:2, w:4, h:4, mode:0, frames:1, exp_outs:4};
    vecs[1] = '{sx:1, sy:1, w:3, h:2, mode:0, frames:1, exp_outs:6};
    vecs[2] = '{sx:3, sy:1, w:5, h:2, mode:0, frames:1, exp_outs:4};
    vecs[3] = '{sx:2, sy:2, w:4, h:4, mode:1, frames:1, exp_outs:4};
    vecs[4] = '{sx:0, sy:0, w:3, h:2, mode:0, frames:1, exp_outs:6};
    vecs[5] = '{sx:2, sy:1, w:4, h:3, mode:2, frames:2, exp_outs:12};

    rst_n = 1'b0;
    config_valid = 1'b0;
    config_stride_x = '0;
    config_stride_y = '0;
    config_row_width = '0;
    config_num_rows = '0;
    datain = '0;
    datain_valid = 1'b0;
    dataout_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dataout_valid", 64'(dataout_valid), 64'd0);
    chk("rst_datain_ready", 64'(datain_ready), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_eol_eof", 64'({dataout_eol, dataout_eof}), 64'd0);
    chk("rst_dataout", dataout, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    datain_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_not_ready", 64'(datain_ready), 64'd0);
    end
    @(posedge clk); #1;
    datain_valid = 1'b0;
    mon_en = 1'b1;

    for (int v = 0; v < 6; v++) begin
      configure(vecs[v].sx, vecs[v].sy, vecs[v].w, vecs[v].h, v != 0);
      rdy_mode = vecs[v].mode;
      out_cnt = 0;
      fd0 = fd_seen;
      esx = (vecs[v].sx == 0) ? 1 : vecs[v].sx;
      esy = (vecs[v].sy == 0) ? 1 : vecs[v].sy;
      run_beats(esx, esy, vecs[v].w, vecs[v].h,
                vecs[v].w * vecs[v].h * vecs[v].frames, 0);
      drain();
      chk($sformatf("vec%0d_out_count", v), 64'(out_cnt), 64'(vecs[v].exp_outs));
      chk($sformatf("vec%0d_frame_done_count", v), 64'(fd_seen - fd0), 64'(vecs[v].frames));
    end

    // One-cycle latency on stride 1,1, leaving the frame unfinished.
    rdy_mode = 0;
    configure(1, 1, 3, 2, 1'b1);
    run_beats(1, 1, 3, 2, 1, 7);
    @(negedge clk);
    chk("latency_valid", 64'(dataout_valid), 64'd1);
    chk("latency_data", dataout, pix(7));
    drain();

    // Restart while a beat is held: the held beat must survive the config.
    rdy_mode = 3;
    repeat (2) @(posedge clk);
    configure(1, 1, 4, 4, 1'b0);
    run_beats(1, 1, 4, 4, 1, 33);
    repeat (2) @(posedge clk);
    configure(1, 1, 4, 4, 1'b0);
    @(negedge clk);
    chk("restart_keeps_valid", 64'(dataout_valid), 64'd1);
    chk("restart_keeps_data", dataout, pix(33));
    rdy_mode = 0;
    drain();

    // Mid-frame reset after 5 beats.
    configure(1, 1, 4, 4, 1'b1);
    run_beats(1, 1, 4, 4, 5, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("reset_mid_valid", 64'(dataout_valid), 64'd0);
    datain_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_mid_not_ready", 64'(datain_ready), 64'd0);
    end
    @(posedge clk); #1;
    datain_valid = 1'b0;
    out_cnt = 0;
    configure(1, 1, 2, 2, 1'b0);
    run_beats(1, 1, 2, 2, 4, 100);
    drain();
    chk("post_reset_out_count", 64'(out_cnt), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
